// File: rtl/spmv_pkg.sv
// Shared widths, the packed CSR entry layout and the reader FSM encoding for the SpMV entry path.
package spmv_pkg;
  localparam int VAL_W  = 32;
  localparam int IDX_W  = 16;
  localparam int DATA_W = VAL_W + IDX_W + 1;

  typedef struct packed {
    logic             last;
    logic [IDX_W-1:0] col;
    logic [VAL_W-1:0] value;
  } csr_entry_t;

  typedef enum logic {RUN, FLUSH} rd_state_t;
endpackage

// File: rtl/csr_entry_reader_if.sv
// Unpacked CSR entry stream toward the MAC stage; valid/ready, data held while stalled.
interface csr_entry_reader_if;
  import spmv_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [VAL_W-1:0] out_value;
  logic [IDX_W-1:0] out_col;
  logic             out_last;

  modport master (output out_valid, out_value, out_col, out_last, input out_ready);
  modport slave  (input out_valid, out_value, out_col, out_last, output out_ready);
endinterface

// File: rtl/stream_buf2.sv
// Two-entry in-order register buffer; head drives rd_data straight from a flop, so output is glitch-free.
// Write and dequeue may coincide at any occupancy; clr empties it without touching the data registers.
module stream_buf2
  import spmv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  csr_entry_t wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output csr_entry_t rd_data,
  output logic [1:0] occ
);
  csr_entry_t slot0;
  csr_entry_t slot1;
  logic       deq;

  assign rd_valid = (occ != 2'd0);
  assign rd_data  = slot0;
  assign deq      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (clr) begin
      occ <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (wr_en) begin
            slot0 <= wr_data;
            occ   <= 2'd1;
          end
        end
        2'd1: begin
          if (wr_en && deq) begin
            slot0 <= wr_data;
          end else if (deq) begin
            occ <= 2'd0;
          end else if (wr_en) begin
            slot1 <= wr_data;
            occ   <= 2'd2;
          end
        end
        default: begin
          if (deq) begin
            slot0 <= slot1;
            if (wr_en) slot1 <= wr_data;
            else       occ   <= 2'd1;
          end
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr)
    !(wr_en && occ == 2'd2 && !deq));
endmodule

// File: rtl/csr_entry_reader.sv
// Pops packed CSR entries from a 1-cycle-latency FIFO and streams them unpacked at 1 entry/cycle.
// Pop-to-out_valid is 2 clocks; pops are throttled so buffered plus in-flight entries never exceed 2.
module csr_entry_reader
  import spmv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_W-1:0]     fifo_data,
  csr_entry_reader_if.master    out,
  output logic                  busy,
  output logic [CNT_W-1:0]      entries_done,
  output logic [CNT_W-1:0]      rows_done
);
  rd_state_t  state;
  logic       inflight;
  logic [1:0] occ;
  logic       deq;
  logic [2:0] pending;
  logic       can_pop;
  csr_entry_t head;

  assign deq = out.out_valid && out.out_ready;
  // Occupancy as it will stand next cycle, before counting a pop issued now.
  assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
  assign can_pop    = en && (state == RUN) && !fifo_empty && (pending < 3'd2);
  assign fifo_rd_en = can_pop && !flush;
  assign busy       = (occ != 2'd0) || inflight || (state == FLUSH);

  stream_buf2 u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .wr_en    (inflight && (state == RUN)),
    .wr_data  (csr_entry_t'(fifo_data)),
    .rd_valid (out.out_valid),
    .rd_ready (out.out_ready),
    .rd_data  (head),
    .occ      (occ)
  );

  assign out.out_value = head.value;
  assign out.out_col   = head.col;
  assign out.out_last  = head.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      inflight     <= 1'b0;
      entries_done <= '0;
      rows_done    <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (deq) entries_done <= entries_done + CNT_W'(1);
      if (deq && head.last) rows_done <= rows_done + CNT_W'(1);
      case (state)
        RUN:     if (flush && (inflight || can_pop)) state <= FLUSH;
        default: state <= RUN;
      endcase
    end
  end
endmodule
